mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the requester and memory ports.
REQ-002 Parameter DATA_W, default 32, read-data width of the requester and memory ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-005 req_valid_i  input  2  per-requester read-request valid (bit 0 = page-table walker, bit 1 = data port).
REQ-006 req_ready_o  output  2  per-requester request accepted this cycle.
REQ-007 req_addr_i  input  2 x ADDR_W  per-requester byte address, packed [1:0][ADDR_W-1:0].
REQ-008 resp_valid_o  output  2  per-requester response valid; at most one bit set.
REQ-009 resp_ready_i  input  2  per-requester response ready.
REQ-010 resp_data_o  output  DATA_W  response data, shared by both requesters, qualified by resp_valid_o.
REQ-011 mem_req_valid_o  output  1  request valid to the memory.
REQ-012 mem_req_ready_i  input  1  memory accepts the request.
REQ-013 mem_addr_o  output  ADDR_W  byte address to the memory.
REQ-014 mem_resp_valid_i  input  1  memory response valid.
REQ-015 mem_resp_ready_o  output  1  arbiter ready for the memory response.
REQ-016 mem_data_i  input  DATA_W  memory read data.
REQ-017 grant_o  output  1  index of the current or most recent owner.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP. One transaction is outstanding at a time.
REQ-020 IDLE: if any req_valid_i bit is set, the winner SHALL get req_ready_o high combinationally in the same cycle. Its address and index are latched, and the FSM moves to ISSUE.
REQ-021 Arbitration SHALL be round-robin using a last_grant pointer. With both requesters valid, the index not equal to last_grant wins. With one requester valid, that one wins regardless of the pointer.
REQ-022 ISSUE: mem_req_valid_o=1 and mem_addr_o equals the latched address, held stable until mem_req_ready_i; then the FSM moves to WAIT.
REQ-023 WAIT: mem_resp_ready_o=1. On mem_resp_valid_i, mem_data_i is latched and the FSM moves to RESP.
REQ-024 RESP: resp_valid_o[owner]=1 and resp_data_o equals the latched data, both held until resp_ready_i[owner]. The FSM then moves to IDLE and last_grant is updated to the owner.
REQ-025 req_ready_o SHALL be 0 outside IDLE. mem_req_valid_o SHALL be 0 outside ISSUE. mem_resp_ready_o SHALL be 0 outside WAIT.
REQ-026 Minimum latency SHALL be: request accepted at cycle N, memory request at N+1, and response to the requester at the cycle after mem_resp_valid_i.
REQ-027 A new request SHALL be accepted no earlier than the cycle after the RESP handshake (one idle cycle between transactions).
REQ-028 The address SHALL be passed through unmodified. Out-of-range data (0 from memory) SHALL be forwarded as-is.
REQ-029 resp_ready_i of the non-owner, and req_valid_i changes while busy, SHALL have no effect.

Reset
REQ-030 On rst=0 at a clock edge, the FSM SHALL go to IDLE and last_grant SHALL be set to 1, so requester 0 wins the first tie.
REQ-031 On rst=0, grant_o=0, busy_o=0, and all valid/ready outputs SHALL be 0. Latched address and data SHALL be cleared to 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction without sending a response. The memory is reset with the same rst.

Structure
REQ-033 The state enum and the requester-index constants (REQ_PTW=0, REQ_DATA=1) SHALL live in shared package tlb_pkg.
REQ-034 The arbiter SHALL be a single module with no sub-modules. The round-robin pick SHALL be inline combinational logic.

Verification
REQ-035 Single request: requester 0 only, addr 400 -> mem_addr_o=400, resp_valid_o=2'b01, resp_data_o=0x20000001.
REQ-036 Tie after reset: both valid, addr0=400, addr1=800 -> requester 0 served first (0x20000001), then requester 1 (0x30000001); grant_o sequence 0,1.
REQ-037 Fairness: both requesters continuously valid for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
REQ-038 Backpressure: mem_req_ready_i held low 3 cycles, then resp_ready_i held low 4 cycles -> mem_addr_o, resp_valid_o and resp_data_o stay stable throughout, with exactly one transaction.
REQ-039 Out-of-bounds: addr 8000 -> resp_data_o=0x00000000 delivered to the requester.
REQ-040 Reset in WAIT: rst=0 for 1 cycle -> next cycle is IDLE with all outputs 0, no resp_valid_o, and a following request completes normally.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types for the two-requester memory read arbiter.
// Holds the arbiter state encoding and the requester index constants.
package tlb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_PTW  = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: two read requesters share one memory port, one transaction in flight.
// Latency: accept at N, mem request at N+1, response the cycle after mem_resp_valid_i; stalls on any ready low.
module mem_arbiter
  import tlb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  output logic [1:0]             resp_valid_o,
  input  logic [1:0]             resp_ready_i,
  output logic [DATA_W-1:0]      resp_data_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic                   mem_resp_valid_i,
  output logic                   mem_resp_ready_o,
  input  logic [DATA_W-1:0]      mem_data_i,
  output logic                   grant_o,
  output logic                   busy_o
);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_any_req;
  logic              w_pick;
  logic              w_accept;

  assign w_any_req = |req_valid_i;
  // On a tie the requester that was not served last wins.
  assign w_pick    = (req_valid_i == 2'b11) ? ~r_last_grant
                   : (req_valid_i[REQ_DATA] ? REQ_DATA : REQ_PTW);
  assign w_accept  = (r_state == S_IDLE) && w_any_req;

  assign mem_addr_o  = r_addr;
  assign resp_data_o = r_data;
  assign grant_o     = r_owner;
  assign busy_o      = (r_state != S_IDLE);

  always_comb begin
    w_next_state     = r_state;
    req_ready_o      = 2'b00;
    resp_valid_o     = 2'b00;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          req_ready_o[w_pick] = 1'b1;
          w_next_state        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) w_next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid_o[r_owner] = 1'b1;
        if (resp_ready_i[r_owner]) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= REQ_PTW;
      r_last_grant <= REQ_DATA;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_owner <= w_pick;
        r_addr  <= req_addr_i[w_pick];
      end
      if ((r_state == S_WAIT) && mem_resp_valid_i) r_data <= mem_data_i;
      if ((r_state == S_RESP) && resp_ready_i[r_owner]) r_last_grant <= r_owner;
    end
  end

endmodule
